// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive packet controller.
package usb_rx_pkg;

   // Receive controller states
   typedef enum logic [2:0] {
      StIdle,
      StHunt,
      StData,
      StEop,
      StErr
   } rx_state_e;

   // Decoded SYNC as seen LSB-first in the hunt register: seven 0s then a 1
   localparam logic [7:0] SYNC_PAT    = 8'h80;
   // Run of 1s after which the transmitter inserts a stuffed 0
   localparam logic [2:0] STUFF_LIMIT = 3'd6;

   // PID byte layout: packet type in the low nibble, its complement in the high nibble
   localparam int unsigned PID_TYPE_LSB = 0;
   localparam int unsigned PID_CHK_LSB  = 4;
   localparam int unsigned PID_FIELD_W  = 4;

   // True when the check nibble is the bitwise complement of the type nibble
   function automatic logic pid_ok(input logic [7:0] pid);
      return pid[PID_TYPE_LSB +: PID_FIELD_W] == ~pid[PID_CHK_LSB +: PID_FIELD_W];
   endfunction

endpackage

// File: rtl/usb_rx_unstuff.sv
// Bit de-stuffing: tracks the run of consecutive 1s and decides, per recovered bit,
// whether the bit is data (bit_keep) or a stuff position carrying an illegal 1 (stuff_err).
module usb_rx_unstuff
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic en,
   input  logic bit_vld,
   input  logic bit_in,
   output logic bit_keep,
   output logic stuff_err
);

   logic [2:0] ones_q;
   logic [2:0] ones_d;
   logic       at_limit;
   logic       live;

   // Keep/drop decision and next ones count
   always_comb begin
      at_limit  = (ones_q == STUFF_LIMIT);
      live      = bit_vld & en;
      bit_keep  = live & ~at_limit;
      stuff_err = live & at_limit & bit_in;
      ones_d    = ones_q;
      if (clr) begin
         ones_d = 3'd0;
      end else if (load) begin
         // The final 1 of SYNC already counts toward the run
         ones_d = 3'd1;
      end else if (live) begin
         ones_d = (at_limit || !bit_in) ? 3'd0 : ones_q + 3'd1;
      end
   end

   // Ones-run counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ones_q <= 3'd0;
      end else begin
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive packet controller: SYNC hunt, de-stuffing, LSB-first byte
// assembly, EOP detection and sticky per-packet framing error flags.
// Optional feature macro: USB_RX_PID_CHECK_EN enables the first-byte PID check driving pid_err;
// without it pid_err is held at 0.
module usb_rx_ctrl
   import usb_rx_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 64,
   parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_en,
   input  logic             bit_vld,
   input  logic             bit_in,
   input  logic             se0,
   output logic             rx_active,
   output logic             pkt_start,
   output logic [7:0]       data_out,
   output logic             data_vld,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             pkt_end,
   output logic             err_stuff,
   output logic             err_align,
   output logic             err_ovf,
   output logic             pid_err
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   rx_state_e  state;
   // Only the upper seven bits of each shift register are ever read back
   logic [6:0] hunt_sr;
   logic [6:0] byte_sr;
   logic [2:0] bit_cnt;
   logic [7:0] hunt_nxt;
   logic [7:0] byte_nxt;
   logic       sync_hit;
   logic       data_en;
   logic       bit_keep;
   logic       stuff_err;
   logic       byte_done;

   // Candidate shift-register values and qualified events for this bit time
   always_comb begin
      hunt_nxt  = {bit_in, hunt_sr};
      byte_nxt  = {bit_in, byte_sr};
      sync_hit  = rx_en & bit_vld & ~se0 & (state == StHunt) & (hunt_nxt == SYNC_PAT);
      data_en   = rx_en & ~se0 & (state == StData);
      byte_done = bit_keep & (bit_cnt == 3'd7);
   end

   usb_rx_unstuff u_unstuff (
      .clk       (clk),
      .rst       (rst),
      .clr       (~rx_en),
      .load      (sync_hit),
      .en        (data_en),
      .bit_vld   (bit_vld),
      .bit_in    (bit_in),
      .bit_keep  (bit_keep),
      .stuff_err (stuff_err)
   );

   // Receive FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         hunt_sr   <= 7'h00;
         byte_sr   <= 7'h00;
         bit_cnt   <= 3'd0;
         rx_active <= 1'b0;
         pkt_start <= 1'b0;
         data_out  <= 8'h00;
         data_vld  <= 1'b0;
         byte_cnt  <= '0;
         pkt_end   <= 1'b0;
         err_stuff <= 1'b0;
         err_align <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         pkt_start <= 1'b0;
         data_vld  <= 1'b0;
         pkt_end   <= 1'b0;
         if (!rx_en) begin
            // Abort: no pkt_end, partial byte dropped
            state     <= StIdle;
            rx_active <= 1'b0;
            bit_cnt   <= 3'd0;
            hunt_sr   <= 7'h7f;
         end else begin
            // Hunt register restarts from idle-line J whenever we are not hunting
            if (state != StHunt) begin
               hunt_sr <= 7'h7f;
            end
            if (bit_vld) begin
               unique case (state)
                  StIdle: state <= StHunt;
                  StHunt: begin
                     if (se0) begin
                        hunt_sr <= 7'h7f;
                     end else if (sync_hit) begin
                        state     <= StData;
                        hunt_sr   <= 7'h7f;
                        pkt_start <= 1'b1;
                        rx_active <= 1'b1;
                        err_stuff <= 1'b0;
                        err_align <= 1'b0;
                        err_ovf   <= 1'b0;
                        byte_cnt  <= '0;
                        bit_cnt   <= 3'd0;
                     end else begin
                        hunt_sr <= hunt_nxt[7:1];
                     end
                  end
                  StData: begin
                     if (se0) begin
                        state <= StEop;
                        if (bit_cnt != 3'd0) begin
                           err_align <= 1'b1;
                        end
                     end else if (stuff_err) begin
                        err_stuff <= 1'b1;
                        state     <= StErr;
                     end else if (bit_keep) begin
                        byte_sr <= byte_nxt[7:1];
                        if (byte_done) begin
                           bit_cnt <= 3'd0;
                           if (byte_cnt == MAX_CNT) begin
                              err_ovf <= 1'b1;
                              state   <= StErr;
                           end else begin
                              data_out <= byte_nxt;
                              data_vld <= 1'b1;
                              byte_cnt <= byte_cnt + 1'b1;
                           end
                        end else begin
                           bit_cnt <= bit_cnt + 3'd1;
                        end
                     end
                  end
                  StEop: begin
                     if (!se0) begin
                        pkt_end   <= 1'b1;
                        rx_active <= 1'b0;
                        state     <= StHunt;
                        // K instead of J after SE0 is a malformed EOP
                        if (!bit_in) begin
                           err_align <= 1'b1;
                        end
                     end
                  end
                  StErr: begin
                     // Remaining EOP handling (wait for J) is shared with StEop
                     if (se0) begin
                        state <= StEop;
                     end
                  end
                  default: state <= StIdle;
               endcase
            end
         end
      end
   end

`ifdef USB_RX_PID_CHECK_EN
   // PID flag: cleared at SYNC, set alongside the first byte's data_vld when it fails the check
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pid_err <= 1'b0;
      end else if (sync_hit) begin
         pid_err <= 1'b0;
      end else if (byte_done && byte_cnt == '0 && !pid_ok(byte_nxt)) begin
         pid_err <= 1'b1;
      end
   end
`else
   assign pid_err = 1'b0;
`endif

endmodule
